instr_ctrl_fsm: RTL and testbench

//  Control unit on the consuming end of the INSTRUCTION stream that the test driver and

---
 rtl/instr_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_instr_ctrl_fsm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_ctrl_fsm.sv
// rtl/instr_ctrl_fsm.sv - instruction stream control unit: load/mov/add/sub sequencing for the datapath
module instr_ctrl_fsm #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int OPC_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  INSTRUCTION,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rd_addr,
    output logic [RADDR_W-1:0] wr_addr,
    output logic               wr_en,
    output logic [1:0]         wr_src,
    output logic               a_ld,
    output logic               g_ld,
    output logic               alu_sub,
    output logic [DATA_W-1:0]  imm_out,
    output logic               done,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int OPC_LO = 2 * RADDR_W;
    localparam int OPC_HI = OPC_LO + OPC_W - 1;

    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_RD  = 2'b01;
    localparam logic [1:0] SRC_G   = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_WR   = 3'd2,
        MOV     = 3'd3,
        AX      = 3'd4,
        AY      = 3'd5,
        WB      = 3'd6,
        ERR     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [RADDR_W-1:0] rx_q, rx_d;
    logic [RADDR_W-1:0] ry_q, ry_d;
    logic               sub_q, sub_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [RADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic               wr_en_q, wr_en_d;
    logic [1:0]         wr_src_q, wr_src_d;
    logic               a_ld_q, a_ld_d;
    logic               g_ld_q, g_ld_d;
    logic               alu_sub_q, alu_sub_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [OPC_W-1:0]   in_opc;
    logic               in_illegal;
    logic               accept;

    assign in_opc      = INSTRUCTION[OPC_HI:OPC_LO];
    assign in_illegal  = (|INSTRUCTION[DATA_W-1:OPC_HI+1]) | in_opc[OPC_W-1];
    assign instr_ready = reset & ((state_q == IDLE) | (state_q == LD_WAIT));
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        sub_d   = sub_q;
        imm_d   = imm_q;
        count_d = count_q + CNT_W'(done_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rx_d  = INSTRUCTION[2*RADDR_W-1:RADDR_W];
                    ry_d  = INSTRUCTION[RADDR_W-1:0];
                    sub_d = in_opc[0];
                    if (in_illegal)     state_d = ERR;
                    else if (in_opc[1]) state_d = AX;
                    else if (in_opc[0]) state_d = MOV;
                    else                state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                // The data word is raw payload and is never decoded.
                if (accept) begin
                    imm_d   = INSTRUCTION;
                    state_d = LD_WR;
                end
            end
            AX:      state_d = AY;
            AY:      state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        rd_addr_d = '0;
        wr_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_src_d  = SRC_IMM;
        a_ld_d    = 1'b0;
        g_ld_d    = 1'b0;
        alu_sub_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            LD_WR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = rx_d;
                wr_src_d  = SRC_IMM;
                done_d    = 1'b1;
            end
            MOV: begin
                rd_addr_d = ry_d;
                wr_en_d   = 1'b1;
                wr_addr_d = rx_d;
                wr_src_d  = SRC_RD;
                done_d    = 1'b1;
            end
            AX: begin
                rd_addr_d = rx_d;
                a_ld_d    = 1'b1;
            end
            AY: begin
                rd_addr_d = ry_d;
                g_ld_d    = 1'b1;
                alu_sub_d = sub_d;
            end
            WB: begin
                wr_en_d   = 1'b1;
                wr_addr_d = rx_d;
                wr_src_d  = SRC_G;
                done_d    = 1'b1;
            end
            ERR:     err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rx_q      <= '0;
            ry_q      <= '0;
            sub_q     <= 1'b0;
            imm_q     <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_src_q  <= SRC_IMM;
            a_ld_q    <= 1'b0;
            g_ld_q    <= 1'b0;
            alu_sub_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            sub_q     <= sub_d;
            imm_q     <= imm_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            wr_src_q  <= wr_src_d;
            a_ld_q    <= a_ld_d;
            g_ld_q    <= g_ld_d;
            alu_sub_q <= alu_sub_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign wr_addr     = wr_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_src      = wr_src_q;
    assign a_ld        = a_ld_q;
    assign g_ld        = g_ld_q;
    assign alu_sub     = alu_sub_q;
    assign imm_out     = imm_q;
    assign done        = done_q;
    assign err_illegal = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// tb/tb_instr_ctrl_fsm.sv - directed self-checking bench for instr_ctrl_fsm
module tb_instr_ctrl_fsm;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] INSTRUCTION;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rd_addr;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic [1:0]  wr_src;
    logic        a_ld;
    logic        g_ld;
    logic        alu_sub;
    logic [15:0] imm_out;
    logic        done;
    logic        err_illegal;
    logic [CNT_W-1:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    instr_ctrl_fsm #(.DATA_W(16), .RADDR_W(4), .OPC_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .INSTRUCTION(INSTRUCTION), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_src(wr_src), .a_ld(a_ld), .g_ld(g_ld), .alu_sub(alu_sub), .imm_out(imm_out),
        .done(done), .err_illegal(err_illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        INSTRUCTION = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        INSTRUCTION = '0;
        instr_valid = 1'b0;
        step();
        step();
        check("rst_ready", instr_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_count", instr_count, 0);
        check("rst_imm", imm_out, 0);
        reset = 1'b1;
        #1;
        check("rel_ready", instr_ready, 1);

        // reset during AY of an add
        send(16'h0231);
        check("t1_ax_ald", a_ld, 1);
        check("t1_ax_rd", rd_addr, 3);
        step();
        check("t1_ay_gld", g_ld, 1);
        reset = 1'b0;
        step();
        check("t1_rst_wr_en", wr_en, 0);
        check("t1_rst_gld", g_ld, 0);
        check("t1_rst_ready", instr_ready, 0);
        reset = 1'b1;
        step();
        check("t1_post_wr_en", wr_en, 0);
        check("t1_post_done", done, 0);
        check("t1_post_ready", instr_ready, 1);
        check("t1_post_count", instr_count, 0);

        // load r1, data 0x0007 with an idle gap before the data word
        send(16'h0016);
        check("t2_wait_ready", instr_ready, 1);
        check("t2_wait_wr_en", wr_en, 0);
        step();
        check("t2_gap_ready", instr_ready, 1);
        check("t2_gap_done", done, 0);
        send(16'h0007);
        check("t2_wr_en", wr_en, 1);
        check("t2_wr_addr", wr_addr, 1);
        check("t2_wr_src", wr_src, 0);
        check("t2_imm", imm_out, 16'h0007);
        check("t2_done", done, 1);
        check("t2_ready", instr_ready, 0);
        step();
        check("t2_count", instr_count, 1);
        check("t2_done_clr", done, 0);

        // mov r3, r2
        send(16'h0132);
        check("t3_rd", rd_addr, 2);
        check("t3_wr", wr_addr, 3);
        check("t3_src", wr_src, 1);
        check("t3_wr_en", wr_en, 1);
        check("t3_done", done, 1);
        step();
        check("t3_count", instr_count, 2);

        // add r3, r1 with a competing word held valid throughout
        send(16'h0231);
        INSTRUCTION = 16'h0132;
        instr_valid = 1'b1;
        check("t4_ax_rd", rd_addr, 3);
        check("t4_ax_ald", a_ld, 1);
        check("t4_ax_ready", instr_ready, 0);
        step();
        check("t4_ay_rd", rd_addr, 1);
        check("t4_ay_gld", g_ld, 1);
        check("t4_ay_sub", alu_sub, 0);
        check("t4_ay_ald", a_ld, 0);
        check("t4_ay_ready", instr_ready, 0);
        step();
        check("t4_wb_wr", wr_addr, 3);
        check("t4_wb_src", wr_src, 2);
        check("t4_wb_wr_en", wr_en, 1);
        check("t4_wb_done", done, 1);
        check("t4_wb_rd", rd_addr, 0);
        check("t4_wb_ready", instr_ready, 0);
        instr_valid = 1'b0;
        step();
        check("t4_idle_wr_en", wr_en, 0);
        check("t4_count", instr_count, 3);
        step();
        check("t4_not_consumed", wr_en, 0);

        // sub r1, r2 then two illegal encodings
        send(16'h0312);
        step();
        check("t5_ay_sub", alu_sub, 1);
        check("t5_ay_rd", rd_addr, 2);
        step();
        check("t5_wb_wr", wr_addr, 1);
        check("t5_wb_done", done, 1);
        step();
        check("t5_count", instr_count, 4);
        send(16'h0612);
        check("t5_opc_err", err_illegal, 1);
        check("t5_opc_wr_en", wr_en, 0);
        check("t5_opc_done", done, 0);
        step();
        check("t5_opc_err_clr", err_illegal, 0);
        send(16'h0812);
        check("t5_hi_err", err_illegal, 1);
        step();
        check("t5_err_count", instr_count, 4);

        // add r5, r5 is legal
        send(16'h0255);
        check("t6_same_ax", rd_addr, 5);
        step();
        check("t6_same_ay", rd_addr, 5);
        step();
        check("t6_same_wb", wr_addr, 5);
        step();
        check("t6_count", instr_count, 5);

        // counter wrap: 10 more movs reach 15, one more wraps to 0
        for (int i = 0; i < 10; i++) begin
            send(16'h0101);
            step();
        end
        check("t6_count_max", instr_count, 15);
        send(16'h0101);
        check("t6_wrap_done", done, 1);
        step();
        check("t6_wrap", instr_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
